regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two sources: the in-order pipeline writeback stage (W) and a long-latency side unit such as an iterative multiply/divide unit.
- W always has priority. Side-unit results are buffered in a small FIFO and drained into free write-port cycles.
- Provides a starvation stall request and a pending-destination query so decode can interlock on buffered results.

Parameters:
- DEPTH, 4, side-result FIFO entries; power of two, at least 2.
- STARVE_LIMIT, 8, consecutive blocked cycles of a valid FIFO head before stall_req asserts.
- CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pipe_we  in  1  W-stage write enable (RegWriteW).
- pipe_rd  in  5  W-stage destination (RdW).
- pipe_wdata  in  32  W-stage result (ResultW).
- side_valid  in  1  side unit presents a result.
- side_rd  in  5  side-unit destination.
- side_wdata  in  32  side-unit result.
- side_ready  out  1  FIFO can accept a result.
- rf_we  out  1  write enable to register file.
- rf_rd  out  5  write address to register file.
- rf_wdata  out  32  write data to register file.
- q_addr  in  5  decode-stage source address to check.
- q_pending  out  1  q_addr matches a live FIFO entry.
- stall_req  out  1  request the pipeline to freeze W for one cycle.

Behaviour:
- Reset clears pointers, count, entry valid bits, starvation counter and statistics. Outputs during reset: side_ready=1, rf_we=0, q_pending=0, stall_req=0.
- pipe_busy = pipe_we and (pipe_rd != 0).
- Write-port selection is combinational, with zero latency from its inputs:
  - If pipe_busy: drive pipe_rd/pipe_wdata with rf_we=1.
  - Otherwise, if the FIFO head is live: drive the head with rf_we=1 and pop it this cycle.
  - Otherwise: rf_we=0.
- A head that is killed (valid bit cleared) is popped silently, without a write, in any cycle.
- Push:
  - side_ready = (count < DEPTH).
  - A result is accepted when side_valid and side_ready; the entry lands at the tail at the clock edge.
  - A push with side_rd == 0 is accepted and discarded; it is not stored.
  - A simultaneous push and pop when full is not allowed: side_ready is based on the registered count only.
- Bypass: if the FIFO is empty, pipe_busy=0 and a result is accepted, it is written directly that cycle (rf_we=1 with side data) and not stored.
- Kill: when pipe_busy and a live entry holds rd == pipe_rd, that entry's valid bit clears at the edge. The W write is younger and wins. Killed entries still occupy slots until they reach the head.
- q_pending = OR over live entries of (rd == q_addr and q_addr != 0). Combinational.
- Starvation counter:
  - Increments each cycle a live head is blocked by pipe_busy.
  - Resets on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
  - stall_req = (counter == STARVE_LIMIT). The pipeline drops pipe_we the next cycle, so the head drains and the counter clears.
- Pointer arithmetic is modulo DEPTH; count is log2(DEPTH)+1 bits wide.
- Reset mid-operation drops every buffered entry. The side unit is reset by the same rst.

Optional Feature:
- Macro: WB_ARB_STATS_EN.
- With the macro defined, three CNT_W-bit saturating counters are added, each exposed as an output port:
  - stat_conflicts: cycles with a live head blocked.
  - stat_kills: entries killed.
  - stat_stalls: cycles with stall_req=1.
  - All three clear on reset.
- Without the macro, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Bypass: empty FIFO, pipe_we=0, side push rd=5 data=0xA5A5_0001 -> same cycle rf_we=1, rf_rd=5, rf_wdata=0xA5A5_0001; count stays 0.
- Priority: pipe_we=1 rd=3 data=0x11 with side push rd=7 data=0x22 -> rf writes x3=0x11; the next free cycle writes x7=0x22; q_addr=7 gives q_pending=1 until that write.
- Kill: queue rd=9 data=0x33, then pipe write rd=9 data=0x44 -> x9 ends at 0x44; the queued entry is popped with no rf_we.
- Full: pipe_busy held, push 4 entries -> side_ready=0 after the 4th; a 5th side_valid is not accepted; release pipe -> 4 writes in FIFO order, side_ready=1 after the first pop.
- Starvation: one entry queued, pipe_busy held -> stall_req=1 on the 9th blocked cycle; pipe_we drops -> entry written and stall_req=0 the next cycle.
- Reset: assert rst with 3 entries queued -> immediately rf_we=0, side_ready=1, q_pending=0; no queued entry is written after release.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - Write-port arbiter bus: pipeline W, side-unit stream, RF write and decode query.
interface regfile_wb_arbiter_if;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wdata;
  logic        side_valid;
  logic [4:0]  side_rd;
  logic [31:0] side_wdata;
  logic        side_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [4:0]  q_addr;
  logic        q_pending;
  logic        stall_req;

  modport slave (
    input  pipe_we, pipe_rd, pipe_wdata, side_valid, side_rd, side_wdata, q_addr,
    output side_ready, rf_we, rf_rd, rf_wdata, q_pending, stall_req
  );

  modport master (
    output pipe_we, pipe_rd, pipe_wdata, side_valid, side_rd, side_wdata, q_addr,
    input  side_ready, rf_we, rf_rd, rf_wdata, q_pending, stall_req
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - Shares the RF write port between W and a buffered side unit; W always wins.
// Optional statistics counters are enabled with `define WB_ARB_STATS_EN.
module regfile_wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_wb_arbiter_if.slave     bus
`ifdef WB_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]        stat_conflicts,
  output logic [CNT_W-1:0]        stat_kills,
  output logic [CNT_W-1:0]        stat_stalls
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  logic [4:0]       rd_q   [DEPTH];
  logic [4:0]       rd_d   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;

  logic pipe_busy, empty, head_vld, side_ready_c, push, bypass, store, pop, blocked;

  always_comb begin
    pipe_busy    = bus.pipe_we && (bus.pipe_rd != 5'd0);
    empty        = (count_q == '0);
    head_vld     = !empty && vld_q[rd_ptr_q];
    side_ready_c = (count_q < DEPTH_C);
    push         = bus.side_valid && side_ready_c && !rst;
    bypass       = push && empty && !pipe_busy && (bus.side_rd != 5'd0);
    store        = push && (bus.side_rd != 5'd0) && !bypass;
    // A killed head leaves silently even while W owns the port.
    pop          = !empty && (!vld_q[rd_ptr_q] || !pipe_busy);
    blocked      = head_vld && pipe_busy;
  end

  always_comb begin
    rd_d     = rd_q;
    data_d   = data_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (pipe_busy && vld_q[i] && (rd_q[i] == bus.pipe_rd)) vld_d[i] = 1'b0;
    end
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
    end
    if (store) begin
      rd_d[wr_ptr_q]   = bus.side_rd;
      data_d[wr_ptr_q] = bus.side_wdata;
      vld_d[wr_ptr_q]  = 1'b1;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    count_d = count_q + (AW+1)'(store) - (AW+1)'(pop);
    if (pop || empty)                      starve_d = '0;
    else if (blocked && starve_q != LIMIT_C) starve_d = starve_q + 1'b1;
    else                                   starve_d = starve_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      rd_q     <= rd_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  // Outputs are forced quiet while rst is high, regardless of pipeline inputs.
  always_comb begin
    bus.side_ready = side_ready_c;
    bus.stall_req  = (starve_q == LIMIT_C);
    bus.rf_we      = 1'b0;
    bus.rf_rd      = 5'd0;
    bus.rf_wdata   = 32'd0;
    if (!rst) begin
      if (pipe_busy) begin
        bus.rf_we    = 1'b1;
        bus.rf_rd    = bus.pipe_rd;
        bus.rf_wdata = bus.pipe_wdata;
      end else if (head_vld) begin
        bus.rf_we    = 1'b1;
        bus.rf_rd    = rd_q[rd_ptr_q];
        bus.rf_wdata = data_q[rd_ptr_q];
      end else if (bypass) begin
        bus.rf_we    = 1'b1;
        bus.rf_rd    = bus.side_rd;
        bus.rf_wdata = bus.side_wdata;
      end
    end
    bus.q_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (rd_q[i] == bus.q_addr) && (bus.q_addr != 5'd0)) bus.q_pending = 1'b1;
    end
  end

`ifdef WB_ARB_STATS_EN
  logic [CNT_W-1:0] conf_q, conf_d, kill_q, kill_d, stall_q, stall_d;
  logic [CNT_W:0]   kill_sum;

  always_comb begin
    kill_sum = {1'b0, kill_q};
    for (int i = 0; i < DEPTH; i++) begin
      if (pipe_busy && vld_q[i] && (rd_q[i] == bus.pipe_rd)) kill_sum = kill_sum + 1'b1;
    end
    kill_d  = kill_sum[CNT_W] ? '1 : kill_sum[CNT_W-1:0];
    conf_d  = (blocked && conf_q != '1) ? conf_q + 1'b1 : conf_q;
    stall_d = (bus.stall_req && stall_q != '1) ? stall_q + 1'b1 : stall_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conf_q  <= '0;
      kill_q  <= '0;
      stall_q <= '0;
    end else begin
      conf_q  <= conf_d;
      kill_q  <= kill_d;
      stall_q <= stall_d;
    end
  end

  assign stat_conflicts = conf_q;
  assign stat_kills     = kill_q;
  assign stat_stalls    = stall_q;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - Directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  regfile_wb_arbiter_if bus ();

`ifdef WB_ARB_STATS_EN
  logic [15:0] stat_conflicts, stat_kills, stat_stalls;
  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .stat_conflicts(stat_conflicts), .stat_kills(stat_kills), .stat_stalls(stat_stalls)
  );
`else
  regfile_wb_arbiter dut (.clk(clk), .rst(rst), .bus(bus.slave));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs just after the falling edge and settle before sampling.
  task automatic drive(input logic pwe, input logic [4:0] prd, input logic [31:0] pdata,
                       input logic sv, input logic [4:0] srd, input logic [31:0] sdata,
                       input logic [4:0] qa);
    @(negedge clk);
    bus.pipe_we    = pwe;
    bus.pipe_rd    = prd;
    bus.pipe_wdata = pdata;
    bus.side_valid = sv;
    bus.side_rd    = srd;
    bus.side_wdata = sdata;
    bus.q_addr     = qa;
    #2;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] d);
    chk({tag, "_we"}, {31'd0, bus.rf_we}, {31'd0, we});
    if (we) begin
      chk({tag, "_rd"}, {27'd0, bus.rf_rd}, {27'd0, rd});
      chk({tag, "_wdata"}, bus.rf_wdata, d);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    bus.pipe_we = 0; bus.pipe_rd = 0; bus.pipe_wdata = 0;
    bus.side_valid = 0; bus.side_rd = 0; bus.side_wdata = 0; bus.q_addr = 0;
    #1 rst = 1'b1;
    #2;
    chk("rst_side_ready", {31'd0, bus.side_ready}, 32'd1);
    chk("rst_rf_we",      {31'd0, bus.rf_we},      32'd0);
    chk("rst_q_pending",  {31'd0, bus.q_pending},  32'd0);
    chk("rst_stall",      {31'd0, bus.stall_req},  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Bypass into an idle port
    drive(0, 0, 0, 1, 5, 32'hA5A5_0001, 5);
    chk_wr("byp", 1, 5, 32'hA5A5_0001);
    chk("byp_qp", {31'd0, bus.q_pending}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 5);
    chk_wr("byp_after", 0, 0, 0);
    chk("byp_after_qp", {31'd0, bus.q_pending}, 32'd0);

    // W priority over side push, then drain
    drive(1, 3, 32'h11, 1, 7, 32'h22, 7);
    chk_wr("prio_w", 1, 3, 32'h11);
    chk("prio_qp0", {31'd0, bus.q_pending}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 7);
    chk_wr("prio_drain", 1, 7, 32'h22);
    chk("prio_qp1", {31'd0, bus.q_pending}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 7);
    chk_wr("prio_idle", 0, 0, 0);
    chk("prio_qp2", {31'd0, bus.q_pending}, 32'd0);

    // Kill of a queued entry by a younger W write
    drive(1, 1, 32'h55, 1, 9, 32'h33, 9);
    chk_wr("kill_q", 1, 1, 32'h55);
    drive(1, 9, 32'h44, 0, 0, 0, 9);
    chk_wr("kill_w", 1, 9, 32'h44);
    chk("kill_qp1", {31'd0, bus.q_pending}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 9);
    chk_wr("kill_silent", 0, 0, 0);
    chk("kill_qp0", {31'd0, bus.q_pending}, 32'd0);
    drive(0, 0, 0, 1, 6, 32'h66, 0);
    chk_wr("kill_empty_byp", 1, 6, 32'h66);

    // Fill to DEPTH while W holds the port
    for (int i = 0; i < 4; i++) begin
      drive(1, 2, 32'hE0, 1, 5'(11 + i), 32'hB1 + i, 0);
      chk("full_ready_pre", {31'd0, bus.side_ready}, 32'd1);
      chk_wr("full_w", 1, 2, 32'hE0);
    end
    drive(1, 2, 32'hE0, 1, 15, 32'hB5, 15);
    chk("full_ready0", {31'd0, bus.side_ready}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 15);
    chk_wr("full_d0", 1, 11, 32'hB1);
    chk("full_ready_pop", {31'd0, bus.side_ready}, 32'd0);
    chk("full_no5th_qp", {31'd0, bus.q_pending}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_wr("full_d1", 1, 12, 32'hB2);
    chk("full_ready1", {31'd0, bus.side_ready}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_wr("full_d2", 1, 13, 32'hB3);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_wr("full_d3", 1, 14, 32'hB4);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_wr("full_empty", 0, 0, 0);

    // Starvation: one entry blocked by a busy W stage
    drive(1, 1, 32'h77, 1, 10, 32'hC0, 0);
    for (int k = 1; k <= 9; k++) begin
      drive(1, 1, 32'h77, 0, 0, 0, 0);
      if (k == 8) chk("starve_k8", {31'd0, bus.stall_req}, 32'd0);
      if (k == 9) chk("starve_k9", {31'd0, bus.stall_req}, 32'd1);
    end
    chk_wr("starve_w", 1, 1, 32'h77);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_wr("starve_drain", 1, 10, 32'hC0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("starve_clear", {31'd0, bus.stall_req}, 32'd0);
    chk_wr("starve_idle", 0, 0, 0);

    // Reset with entries queued
    drive(1, 4, 32'h1, 1, 17, 32'hD1, 0);
    drive(1, 4, 32'h1, 1, 18, 32'hD2, 0);
    drive(1, 4, 32'h1, 1, 19, 32'hD3, 0);
    @(negedge clk);
    bus.pipe_we = 0; bus.side_valid = 0; bus.q_addr = 17;
    rst = 1'b1;
    #2;
    chk("rstq_rf_we", {31'd0, bus.rf_we}, 32'd0);
    chk("rstq_ready", {31'd0, bus.side_ready}, 32'd1);
    chk("rstq_qp",    {31'd0, bus.q_pending}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 18);
    chk_wr("rstq_after0", 0, 0, 0);
    chk("rstq_after_qp", {31'd0, bus.q_pending}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 19);
    chk_wr("rstq_after1", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
